// File: rtl/mips_mc_ctrl_if.sv
// Control bus between the multi-cycle sequencer and the MIPS datapath.
// The sequencer side (master) drives every enable, mux select and status flag.
interface mips_mc_ctrl_if;
  logic       run;
  logic [5:0] op;
  logic       mem_ready;

  logic       pcwrite;
  logic       pcwritecond;
  logic       iord;
  logic       memread;
  logic       memwrite;
  logic       irwrite;
  logic       memtoreg;
  logic       regdst;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] aluop;
  logic [1:0] pcsrc;
  logic [3:0] state;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  run, op, mem_ready,
    output pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
           memtoreg, regdst, regwrite, alusrca, alusrcb, aluop, pcsrc,
           state, instr_done, illegal
  );

  modport slave (
    output run, op, mem_ready,
    input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
           memtoreg, regdst, regwrite, alusrca, alusrcb, aluop, pcsrc,
           state, instr_done, illegal
  );
endinterface

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS sequencer: fetch/decode/execute/memory/writeback FSM with memory stall.
// Define MIPS_MC_PERF_CNT_EN to add cycle and retired-instruction counters.
module mips_mc_ctrl #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int CNT_W         = 32
) (
  input  logic               clk,
  input  logic               reset,
  mips_mc_ctrl_if.master     bus
`ifdef MIPS_MC_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   cyc_cnt,
  output logic [CNT_W-1:0]   ret_cnt
`endif
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       instr_done;
  } ctrl_t;

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic       illegal_q, illegal_d;
  logic       mem_ok;
  ctrl_t      ctrl;

  assign mem_ok = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d = state_q;
    op_d    = op_q;
    ctrl    = '0;

    unique case (state_q)
      S_FETCH: begin
        if (bus.run) begin
          ctrl.memread = 1'b1;
          ctrl.alusrcb = 2'b01;
          ctrl.irwrite = mem_ok;
          ctrl.pcwrite = mem_ok;
          if (mem_ok) state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target is precomputed into ALU-out while the opcode is decoded.
        ctrl.alusrcb = 2'b11;
        op_d         = bus.op;
        case (bus.op)
          OP_RTYPE:       state_d = S_EXEC;
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_BEQ:         state_d = S_BRANCH;
          OP_ADDI, OP_ORI: state_d = S_IEXEC;
          OP_J:           state_d = S_JUMP;
          default:        state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
        state_d      = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        ctrl.memread = 1'b1;
        ctrl.iord    = 1'b1;
        if (mem_ok) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl.regwrite   = 1'b1;
        ctrl.memtoreg   = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
      S_MEMWR: begin
        ctrl.memwrite   = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = mem_ok;
        if (mem_ok) state_d = S_FETCH;
      end
      S_EXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = 2'b10;
        state_d      = S_ALUWB;
      end
      S_ALUWB: begin
        ctrl.regdst     = 1'b1;
        ctrl.regwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alusrca     = 1'b1;
        ctrl.aluop       = 2'b01;
        ctrl.pcwritecond = 1'b1;
        ctrl.pcsrc       = 2'b01;
        ctrl.instr_done  = 1'b1;
        state_d          = S_FETCH;
      end
      S_IEXEC: begin
        // The latched opcode selects the ALU op; the live op may already be stale.
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
        ctrl.aluop   = (op_q == OP_ORI) ? 2'b11 : 2'b00;
        state_d      = S_IWB;
      end
      S_IWB: begin
        ctrl.regwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pcwrite    = 1'b1;
        ctrl.pcsrc      = 2'b10;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase

    // Strobes drop the moment reset rises, not at the next edge.
    if (reset) ctrl = '0;

    illegal_d = illegal_q | (state_d == S_TRAP);
  end

  assign bus.pcwrite     = ctrl.pcwrite;
  assign bus.pcwritecond = ctrl.pcwritecond;
  assign bus.iord        = ctrl.iord;
  assign bus.memread     = ctrl.memread;
  assign bus.memwrite    = ctrl.memwrite;
  assign bus.irwrite     = ctrl.irwrite;
  assign bus.memtoreg    = ctrl.memtoreg;
  assign bus.regdst      = ctrl.regdst;
  assign bus.regwrite    = ctrl.regwrite;
  assign bus.alusrca     = ctrl.alusrca;
  assign bus.alusrcb     = ctrl.alusrcb;
  assign bus.aluop       = ctrl.aluop;
  assign bus.pcsrc       = ctrl.pcsrc;
  assign bus.instr_done  = ctrl.instr_done;
  assign bus.state       = state_q;
  assign bus.illegal     = illegal_q;

`ifdef MIPS_MC_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [CNT_W-1:0] ret_cnt_q, ret_cnt_d;

  always_comb begin
    cyc_cnt_d = cyc_cnt_q;
    ret_cnt_d = ret_cnt_q;
    // Idle fetch and the trap state do not count as busy cycles.
    if (!((state_q == S_FETCH && !bus.run) || state_q == S_TRAP))
      cyc_cnt_d = cyc_cnt_q + CNT_ONE;
    if (ctrl.instr_done)
      ret_cnt_d = ret_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_cnt_q <= '0;
      ret_cnt_q <= '0;
    end else begin
      cyc_cnt_q <= cyc_cnt_d;
      ret_cnt_q <= ret_cnt_d;
    end
  end

  assign cyc_cnt = cyc_cnt_q;
  assign ret_cnt = ret_cnt_q;
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: per-cycle vector table plus trap, async-reset
// and (with MIPS_MC_PERF_CNT_EN) counter sequences.
module tb_mips_mc_ctrl;

  logic clk;
  logic reset;

  mips_mc_ctrl_if bus ();

`ifdef MIPS_MC_PERF_CNT_EN
  logic [31:0] cyc_cnt;
  logic [31:0] ret_cnt;
`endif

  mips_mc_ctrl #(.MEM_HANDSHAKE(1'b1), .CNT_W(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.master)
`ifdef MIPS_MC_PERF_CNT_EN
    ,
    .cyc_cnt (cyc_cnt),
    .ret_cnt (ret_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected control word layout:
  // {pcwrite,pcwritecond,iord,memread,memwrite,irwrite,memtoreg,regdst,regwrite},
  //  alusrca, alusrcb[1:0], aluop[1:0], pcsrc[1:0], instr_done, illegal
  localparam logic [17:0] E_IDLE = {9'b000000000, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
  localparam logic [17:0] E_F1   = {9'b100101000, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0};
  localparam logic [17:0] E_F0   = {9'b000100000, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0};
  localparam logic [17:0] E_DEC  = {9'b000000000, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0};
  localparam logic [17:0] E_MADR = {9'b000000000, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
  localparam logic [17:0] E_MRD  = {9'b001100000, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
  localparam logic [17:0] E_MWB  = {9'b000000101, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
  localparam logic [17:0] E_MWR0 = {9'b001010000, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
  localparam logic [17:0] E_MWR1 = {9'b001010000, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
  localparam logic [17:0] E_EXEC = {9'b000000000, 1'b1, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0};
  localparam logic [17:0] E_AWB  = {9'b000000011, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
  localparam logic [17:0] E_BR   = {9'b010000000, 1'b1, 2'b00, 2'b01, 2'b01, 1'b1, 1'b0};
  localparam logic [17:0] E_IEXA = {9'b000000000, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
  localparam logic [17:0] E_IEXO = {9'b000000000, 1'b1, 2'b10, 2'b11, 2'b00, 1'b0, 1'b0};
  localparam logic [17:0] E_IWB  = {9'b000000001, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
  localparam logic [17:0] E_JMP  = {9'b100000000, 1'b0, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0};
  localparam logic [17:0] E_TRAP = {9'b000000000, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1};

  typedef struct {
    logic        run;
    logic [5:0]  op;
    logic        mem_ready;
    logic [3:0]  st;
    logic [17:0] ctl;
  } vec_t;

  vec_t vecs[$];
  int   passed;
  int   total;

  function automatic logic [17:0] act_ctl();
    return {bus.pcwrite, bus.pcwritecond, bus.iord, bus.memread, bus.memwrite,
            bus.irwrite, bus.memtoreg, bus.regdst, bus.regwrite, bus.alusrca,
            bus.alusrcb, bus.aluop, bus.pcsrc, bus.instr_done, bus.illegal};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic add(input logic r, input logic [5:0] o, input logic m,
                     input logic [3:0] s, input logic [17:0] c);
    vec_t v;
    v.run = r; v.op = o; v.mem_ready = m; v.st = s; v.ctl = c;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic [5:0] o, input logic m);
    bus.run = r; bus.op = o; bus.mem_ready = m;
  endtask

  initial begin
    passed = 0;
    total  = 0;

    // lw: 0,1,2,3,4
    add(1, 6'h23, 1, 4'd0, E_F1);
    add(1, 6'h23, 1, 4'd1, E_DEC);
    add(1, 6'h23, 1, 4'd2, E_MADR);
    add(1, 6'h23, 1, 4'd3, E_MRD);
    add(1, 6'h23, 1, 4'd4, E_MWB);
    // sw with three stall cycles in MEMWR
    add(1, 6'h2b, 1, 4'd0, E_F1);
    add(1, 6'h2b, 1, 4'd1, E_DEC);
    add(1, 6'h2b, 1, 4'd2, E_MADR);
    add(1, 6'h2b, 0, 4'd5, E_MWR0);
    add(1, 6'h2b, 0, 4'd5, E_MWR0);
    add(1, 6'h2b, 0, 4'd5, E_MWR0);
    add(1, 6'h2b, 1, 4'd5, E_MWR1);
    // beq
    add(1, 6'h04, 1, 4'd0, E_F1);
    add(1, 6'h04, 1, 4'd1, E_DEC);
    add(1, 6'h04, 1, 4'd8, E_BR);
    // ori, op switched to R-type after decode
    add(1, 6'h0d, 1, 4'd0, E_F1);
    add(1, 6'h0d, 1, 4'd1, E_DEC);
    add(1, 6'h00, 1, 4'd9, E_IEXO);
    add(1, 6'h00, 1, 4'd10, E_IWB);
    // R-type
    add(1, 6'h00, 1, 4'd0, E_F1);
    add(1, 6'h00, 1, 4'd1, E_DEC);
    add(1, 6'h00, 1, 4'd6, E_EXEC);
    add(1, 6'h00, 1, 4'd7, E_AWB);
    // addi
    add(1, 6'h08, 1, 4'd0, E_F1);
    add(1, 6'h08, 1, 4'd1, E_DEC);
    add(1, 6'h08, 1, 4'd9, E_IEXA);
    add(1, 6'h08, 1, 4'd10, E_IWB);
    // run=0 idle for five cycles
    for (int i = 0; i < 5; i++) add(0, 6'h02, 1, 4'd0, E_IDLE);
    // fetch stalled by memory, then j
    add(1, 6'h02, 0, 4'd0, E_F0);
    add(1, 6'h02, 1, 4'd0, E_F1);
    add(1, 6'h02, 1, 4'd1, E_DEC);
    add(1, 6'h02, 1, 4'd11, E_JMP);
    // lw with one stall cycle in MEMRD
    add(1, 6'h23, 1, 4'd0, E_F1);
    add(1, 6'h23, 1, 4'd1, E_DEC);
    add(1, 6'h23, 1, 4'd2, E_MADR);
    add(1, 6'h23, 0, 4'd3, E_MRD);
    add(1, 6'h23, 1, 4'd3, E_MRD);
    add(1, 6'h23, 1, 4'd4, E_MWB);
    // run drops mid-instruction: the j still completes, then fetch idles
    add(1, 6'h02, 1, 4'd0, E_F1);
    add(0, 6'h02, 1, 4'd1, E_DEC);
    add(0, 6'h02, 1, 4'd11, E_JMP);
    add(0, 6'h02, 1, 4'd0, E_IDLE);

    // Reset state, with run high to show strobes stay low under reset
    reset = 1'b1;
    drive(1, 6'h23, 1);
    #2;
    check("reset state", {28'd0, bus.state}, 32'd0);
    check("reset ctrl", {14'd0, act_ctl()}, {14'd0, E_IDLE});
    drive(0, 6'h00, 1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].run, vecs[i].op, vecs[i].mem_ready);
      #2;
      check($sformatf("vec%0d state", i), {28'd0, bus.state}, {28'd0, vecs[i].st});
      check($sformatf("vec%0d ctrl", i), {14'd0, act_ctl()}, {14'd0, vecs[i].ctl});
      @(negedge clk);
    end

    // Illegal opcode: trap is sticky until reset
    drive(1, 6'h3f, 1);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      #2;
      check($sformatf("trap%0d state", i), {28'd0, bus.state}, 32'd12);
      check($sformatf("trap%0d ctrl", i), {14'd0, act_ctl()}, {14'd0, E_TRAP});
      @(negedge clk);
    end
    #2;
    reset = 1'b1;
    #1;
    check("trap reset state", {28'd0, bus.state}, 32'd0);
    check("trap reset illegal", {31'd0, bus.illegal}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Reset in the middle of a stalled store drops memwrite without a clock edge
    drive(1, 6'h2b, 1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    drive(1, 6'h2b, 0);
    #2;
    check("sw stall memwrite", {31'd0, bus.memwrite}, 32'd1);
    reset = 1'b1;
    #1;
    check("async reset memwrite", {31'd0, bus.memwrite}, 32'd0);
    check("async reset state", {28'd0, bus.state}, 32'd0);
    drive(0, 6'h00, 1);
    @(negedge clk);
    reset = 1'b0;

`ifdef MIPS_MC_PERF_CNT_EN
    begin
      logic [31:0] cyc_idle;
      repeat (2) @(negedge clk);
      check("cyc after idle", cyc_cnt, 32'd0);
      for (int k = 0; k < 3; k++) begin
        drive(1, 6'h02, 1);
        repeat (3) @(negedge clk);
      end
      drive(0, 6'h00, 1);
      cyc_idle = cyc_cnt;
      repeat (5) @(negedge clk);
      check("cyc held while idle", cyc_cnt, cyc_idle);
      check("cyc after three j", cyc_cnt, 32'd9);
      check("ret after three j", ret_cnt, 32'd3);
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
